// File: rtl/video_pkg.sv
// Shared video constants: RGB565 field layout, transparent key, screen coordinate width.
// Also holds the half-transparency field average used by the mixer.
package video_pkg;

  localparam int COORD_W = 10;
  localparam int R_LSB   = 11;
  localparam int G_LSB   = 5;
  localparam int B_LSB   = 0;

  localparam logic [15:0] KEY_RGB_DEF = 16'hF81F;
  localparam logic [2:0]  CH_NONE     = 3'd7;

  // Per-field truncated average of a sprite and a background RGB565 pixel.
  function automatic logic [15:0] rgb_half(input logic [15:0] s, input logic [15:0] b);
    logic [5:0] r;
    logic [6:0] g;
    logic [5:0] bl;
    r  = {1'b0, s[R_LSB +: 5]} + {1'b0, b[R_LSB +: 5]};
    g  = {1'b0, s[G_LSB +: 6]} + {1'b0, b[G_LSB +: 6]};
    bl = {1'b0, s[B_LSB +: 5]} + {1'b0, b[B_LSB +: 5]};
    return {r[5:1], g[6:1], bl[5:1]};
  endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// One sprite channel: frame-latched shadows, hit test, mirroring and ROM address (S1),
// plus the hit/half flags delayed to line up with the ROM data return (S2).
module sprite_hit_addr
  import video_pkg::*;
#(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 14
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               toward,
  input  logic [ADDR_W-1:0]  base,
  input  logic               half,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               hit_d,
  output logic               half_d
);

  localparam int XW = $clog2(SPR_W);

  logic               en_sh, tw_sh, half_sh;
  logic [COORD_W-1:0] x_sh, y_sh;
  logic [ADDR_W-1:0]  base_sh;

  logic [COORD_W:0]   dx, dy, lx;
  logic               hit, hit_q, half_q;
  logic [ADDR_W-1:0]  addr_next;

  // The extra top bit is the borrow: a pixel left of / above the sprite never wraps into it.
  assign dx  = {1'b0, pix_x} - {1'b0, x_sh};
  assign dy  = {1'b0, pix_y} - {1'b0, y_sh};
  assign hit = en_sh & ~dx[COORD_W] & ~dy[COORD_W]
             & (dx[COORD_W-1:0] < COORD_W'(SPR_W))
             & (dy[COORD_W-1:0] < COORD_W'(SPR_H));
  assign lx        = tw_sh ? (COORD_W+1)'(SPR_W - 1) - dx : dx;
  assign addr_next = base_sh + ADDR_W'({dy, {XW{1'b0}}}) + ADDR_W'(lx);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      en_sh    <= 1'b0;
      tw_sh    <= 1'b0;
      half_sh  <= 1'b0;
      x_sh     <= '0;
      y_sh     <= '0;
      base_sh  <= '0;
      rom_addr <= '0;
      hit_q    <= 1'b0;
      half_q   <= 1'b0;
      hit_d    <= 1'b0;
      half_d   <= 1'b0;
    end else begin
      if (frame_start) begin
        en_sh   <= en;
        tw_sh   <= toward;
        half_sh <= half;
        x_sh    <= x;
        y_sh    <= y;
        base_sh <= base;
      end
      rom_addr <= addr_next;
      hit_q    <= hit;
      half_q   <= half_sh;
      hit_d    <= hit_q;
      half_d   <= half_q;
    end
  end

endmodule

// File: rtl/video_sprite_mixer.sv
// N-channel sprite compositor: fixed-priority colour-keyed overlay on the background, 3-cycle latency,
// no backpressure. Optional half transparency under `VIDEO_MIX_HALF_ALPHA_EN.
module video_sprite_mixer
  import video_pkg::*;
#(
  parameter int          N_CH    = 4,
  parameter int          SPR_W   = 64,
  parameter int          SPR_H   = 64,
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] KEY_RGB = KEY_RGB_DEF
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [COORD_W-1:0]        pix_x,
  input  logic [COORD_W-1:0]        pix_y,
  input  logic [15:0]               bg_rgb,
  input  logic [N_CH-1:0]           ch_en,
  input  logic [N_CH*COORD_W-1:0]   ch_x,
  input  logic [N_CH*COORD_W-1:0]   ch_y,
  input  logic [N_CH-1:0]           ch_toward,
  input  logic [N_CH*ADDR_W-1:0]    ch_base,
  input  logic [N_CH-1:0]           ch_half,
  output logic [N_CH*ADDR_W-1:0]    rom_addr,
  input  logic [N_CH*16-1:0]        rom_data,
  output logic                      out_valid,
  output logic [15:0]               out_rgb,
  output logic [2:0]                out_ch,
  output logic                      collision
);

  logic [N_CH-1:0] hit_d, half_d, opaque;
  logic            vld_q, vld_d, acc, pair;
  logic [15:0]     bg_q, bg_d, win_rgb, mix_rgb;
  logic [2:0]      win_ch;
  logic            win_half, win_found;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sprite_hit_addr #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W)) u_ch (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .frame_start (frame_start),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .en          (ch_en[i]),
      .x           (ch_x[COORD_W*i +: COORD_W]),
      .y           (ch_y[COORD_W*i +: COORD_W]),
      .toward      (ch_toward[i]),
      .base        (ch_base[ADDR_W*i +: ADDR_W]),
      .half        (ch_half[i]),
      .rom_addr    (rom_addr[ADDR_W*i +: ADDR_W]),
      .hit_d       (hit_d[i]),
      .half_d      (half_d[i])
    );
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_q <= 1'b0;
      vld_d <= 1'b0;
      bg_q  <= '0;
      bg_d  <= '0;
    end else begin
      vld_q <= pix_valid;
      vld_d <= vld_q;
      bg_q  <= bg_rgb;
      bg_d  <= bg_q;
    end
  end

  always_comb begin
    opaque = '0;
    for (int i = 0; i < N_CH; i++) opaque[i] = hit_d[i] & (rom_data[16*i +: 16] != KEY_RGB);
  end

  always_comb begin
    win_found = 1'b0;
    win_ch    = CH_NONE;
    win_rgb   = bg_d;
    win_half  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (opaque[i] && !win_found) begin
        win_found = 1'b1;
        win_ch    = 3'(i);
        win_rgb   = rom_data[16*i +: 16];
        win_half  = half_d[i];
      end
    end
  end

`ifdef VIDEO_MIX_HALF_ALPHA_EN
  assign mix_rgb = (win_found && win_half) ? rgb_half(win_rgb, bg_d) : win_rgb;
`else
  logic half_unused;
  assign half_unused = win_half;
  assign mix_rgb     = win_rgb;
`endif

  assign pair = vld_d & opaque[0] & opaque[1];

  // A colliding pixel coincident with frame_start seeds the new frame's accumulator.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_ch    <= CH_NONE;
      collision <= 1'b0;
      acc       <= 1'b0;
    end else begin
      out_valid <= vld_d;
      out_rgb   <= mix_rgb;
      out_ch    <= win_ch;
      if (frame_start) begin
        collision <= acc;
        acc       <= pair;
      end else begin
        acc <= acc | pair;
      end
    end
  end

endmodule

// File: tb/tb_video_sprite_mixer.sv
// Self-checking bench for video_sprite_mixer: directed scenarios plus a randomized pixel stream
// checked against a coordinate-arithmetic reference model with a behavioural sprite ROM.
module tb_video_sprite_mixer;

  localparam int N_CH = 4;
  localparam int AW   = 14;
  localparam logic [15:0] KEY = 16'hF81F;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              frame_start = 1'b0;
  logic              pix_valid = 1'b0;
  logic [9:0]        pix_x = '0, pix_y = '0;
  logic [15:0]       bg_rgb = '0;
  logic [N_CH-1:0]   ch_en = '0, ch_toward = '0, ch_half = '0;
  logic [N_CH*10-1:0] ch_x = '0, ch_y = '0;
  logic [N_CH*AW-1:0] ch_base = '0;
  logic [N_CH*AW-1:0] rom_addr;
  logic [N_CH*16-1:0] rom_data;
  logic              out_valid, collision;
  logic [15:0]       out_rgb;
  logic [2:0]        out_ch;

  int n_vec = 0;
  int n_err = 0;
  logic [N_CH*AW-1:0] addr_snap;

  logic [15:0] rom_mem [N_CH][1<<AW];
  bit m_en [N_CH], m_tw [N_CH], m_half [N_CH];
  int m_x [N_CH], m_y [N_CH], m_base [N_CH];

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    for (int i = 0; i < N_CH; i++) rom_data[i*16 +: 16] <= rom_mem[i][rom_addr[i*AW +: AW]];

  video_sprite_mixer #(.N_CH(N_CH), .SPR_W(64), .SPR_H(64), .ADDR_W(AW), .KEY_RGB(KEY)) dut (
    .CLK(CLK), .RSTn(RSTn), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .bg_rgb(bg_rgb), .ch_en(ch_en), .ch_x(ch_x), .ch_y(ch_y),
    .ch_toward(ch_toward), .ch_base(ch_base), .ch_half(ch_half), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_rgb(out_rgb), .out_ch(out_ch),
    .collision(collision)
  );

  // Reference: sprite rectangles in screen space, first opaque channel in index order wins.
  function automatic void model(input int px, input int py, input logic [15:0] bg,
                                output logic [15:0] rgb, output logic [2:0] ch);
    bit found = 0;
    rgb = bg;
    ch  = 3'd7;
    for (int i = 0; i < N_CH; i++) begin
      int dx = px - m_x[i];
      int dy = py - m_y[i];
      if (!found && m_en[i] && dx >= 0 && dx < 64 && dy >= 0 && dy < 64) begin
        int lx = m_tw[i] ? 63 - dx : dx;
        int a  = (m_base[i] + dy * 64 + lx) % (1 << AW);
        logic [15:0] d = rom_mem[i][a];
        if (d != KEY) begin
          found = 1;
          ch    = 3'(i);
          rgb   = d;
`ifdef VIDEO_MIX_HALF_ALPHA_EN
          if (m_half[i]) begin
            int r = ((int'(d[15:11]) + int'(bg[15:11])) / 2);
            int g = ((int'(d[10:5])  + int'(bg[10:5]))  / 2);
            int b = ((int'(d[4:0])   + int'(bg[4:0]))   / 2);
            rgb = 16'(r * 2048 + g * 32 + b);
          end
`endif
        end
      end
    end
  endfunction

  task automatic set_ch(input int i, input bit en, input int x, input int y,
                        input bit tw, input int base, input bit half);
    ch_en[i] = en; ch_toward[i] = tw; ch_half[i] = half;
    ch_x[i*10 +: 10] = 10'(x);
    ch_y[i*10 +: 10] = 10'(y);
    ch_base[i*AW +: AW] = AW'(base);
  endtask

  task automatic clear_ch();
    for (int i = 0; i < N_CH; i++) set_ch(i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_rom(input int i, input logic [15:0] v);
    for (int a = 0; a < (1 << AW); a++) rom_mem[i][a] = v;
  endtask

  task automatic frame();
    @(negedge CLK);
    frame_start = 1; pix_valid = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_en[i] = ch_en[i]; m_tw[i] = ch_toward[i]; m_half[i] = ch_half[i];
      m_x[i] = int'(ch_x[i*10 +: 10]); m_y[i] = int'(ch_y[i*10 +: 10]);
      m_base[i] = int'(ch_base[i*AW +: AW]);
    end
    @(negedge CLK);
    frame_start = 0;
  endtask

  // Presents one pixel, snapshots rom_addr one cycle later, returns once its output is visible.
  task automatic send_pix(input int x, input int y, input logic [15:0] bg, input bit v);
    @(negedge CLK);
    pix_valid = v; pix_x = 10'(x); pix_y = 10'(y); bg_rgb = bg;
    @(posedge CLK); #1;
    addr_snap = rom_addr;
    @(negedge CLK);
    pix_valid = 0;
    @(posedge CLK); @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_rgb !== 16'h0) begin n_err++; $display("FAIL reset_rgb got=%h exp=0000", out_rgb); end
    n_vec++; if (out_ch !== 3'd7) begin n_err++; $display("FAIL reset_ch got=%0d exp=7", out_ch); end
    n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL reset_coll got=%b exp=0", collision); end
    n_vec++; if (rom_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", rom_addr); end
    @(negedge CLK); RSTn = 1;
  endtask

  task automatic test_basic();
    logic [15:0] er; logic [2:0] ec;
    clear_ch();
    fill_rom(0, 16'h07E0); fill_rom(1, 16'h001F);
    set_ch(0, 1, 100, 50, 0, 0, 0);
    set_ch(1, 1, 1000, 50, 0, 0, 0);
    frame();
    send_pix(100, 50, 16'h1234, 1);
    n_vec++; if (out_rgb !== 16'h07E0 || out_ch !== 3'd0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_hit got=%h/%0d/%b exp=07e0/0/1", out_rgb, out_ch, out_valid); end
    send_pix(164, 50, 16'h1234, 1);
    n_vec++; if (out_rgb !== 16'h1234 || out_ch !== 3'd7) begin
      n_err++; $display("FAIL basic_right_edge got=%h/%0d exp=1234/7", out_rgb, out_ch); end
    send_pix(163, 113, 16'h4321, 1);
    model(163, 113, 16'h4321, er, ec);
    n_vec++; if (out_rgb !== er || out_ch !== ec) begin
      n_err++; $display("FAIL basic_corner got=%h/%0d exp=%h/%0d", out_rgb, out_ch, er, ec); end
    send_pix(0, 50, 16'h5555, 1);
    n_vec++; if (out_ch !== 3'd7 || out_rgb !== 16'h5555) begin
      n_err++; $display("FAIL basic_no_wrap got=%h/%0d exp=5555/7", out_rgb, out_ch); end
    send_pix(1010, 60, 16'h5555, 1);
    n_vec++; if (out_ch !== 3'd1 || out_rgb !== 16'h001F) begin
      n_err++; $display("FAIL basic_ch1_far got=%h/%0d exp=001f/1", out_rgb, out_ch); end
  endtask

  task automatic test_mirror();
    clear_ch();
    set_ch(0, 1, 100, 50, 1, 0, 0);
    frame();
    send_pix(100, 50, 16'h0, 1);
    n_vec++; if (addr_snap[AW-1:0] !== 14'd63) begin
      n_err++; $display("FAIL mirror_left got=%0d exp=63", addr_snap[AW-1:0]); end
    send_pix(163, 50, 16'h0, 1);
    n_vec++; if (addr_snap[AW-1:0] !== 14'd0) begin
      n_err++; $display("FAIL mirror_right got=%0d exp=0", addr_snap[AW-1:0]); end
    set_ch(0, 1, 100, 50, 0, 1000, 0);
    frame();
    send_pix(105, 52, 16'h0, 1);
    n_vec++; if (addr_snap[AW-1:0] !== 14'(1000 + 2*64 + 5)) begin
      n_err++; $display("FAIL addr_base got=%0d exp=%0d", addr_snap[AW-1:0], 1000 + 2*64 + 5); end
  endtask

  task automatic test_priority();
    clear_ch();
    fill_rom(0, 16'h07E0); fill_rom(2, 16'h001F);
    set_ch(0, 1, 100, 50, 0, 0, 0);
    set_ch(2, 1, 100, 50, 0, 0, 0);
    frame();
    send_pix(120, 60, 16'hAAAA, 1);
    n_vec++; if (out_ch !== 3'd0 || out_rgb !== 16'h07E0) begin
      n_err++; $display("FAIL prio_ch0 got=%h/%0d exp=07e0/0", out_rgb, out_ch); end
    rom_mem[0][10*64 + 20] = KEY;
    send_pix(120, 60, 16'hAAAA, 1);
    n_vec++; if (out_ch !== 3'd2 || out_rgb !== 16'h001F) begin
      n_err++; $display("FAIL prio_key got=%h/%0d exp=001f/2", out_rgb, out_ch); end
    fill_rom(0, 16'h07E0);
  endtask

  task automatic test_collision();
    clear_ch();
    fill_rom(0, 16'h07E0); fill_rom(1, 16'h001F);
    set_ch(0, 1, 200, 200, 0, 0, 0);
    set_ch(1, 1, 210, 200, 0, 0, 0);
    frame();
    send_pix(215, 210, 16'h0, 1);
    repeat (3) @(negedge CLK);
    n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL coll_midframe got=%b exp=0", collision); end
    frame();
    n_vec++; if (collision !== 1'b1) begin n_err++; $display("FAIL coll_report got=%b exp=1", collision); end
    send_pix(215, 210, 16'h0, 0);
    send_pix(205, 210, 16'h0, 1);
    frame();
    n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL coll_clear got=%b exp=0", collision); end
  endtask

  task automatic test_shadow();
    clear_ch();
    set_ch(0, 1, 100, 50, 0, 0, 0);
    frame();
    set_ch(0, 1, 300, 50, 0, 0, 0);
    send_pix(100, 50, 16'h0F0F, 1);
    n_vec++; if (out_ch !== 3'd0) begin n_err++; $display("FAIL shadow_hold got=%0d exp=0", out_ch); end
    send_pix(300, 50, 16'h0F0F, 1);
    n_vec++; if (out_ch !== 3'd7) begin n_err++; $display("FAIL shadow_early got=%0d exp=7", out_ch); end
    frame();
    send_pix(300, 50, 16'h0F0F, 1);
    n_vec++; if (out_ch !== 3'd0) begin n_err++; $display("FAIL shadow_load got=%0d exp=0", out_ch); end
  endtask

  task automatic test_half();
    logic [15:0] exp_rgb;
`ifdef VIDEO_MIX_HALF_ALPHA_EN
    exp_rgb = 16'h780F;
`else
    exp_rgb = 16'hF800;
`endif
    clear_ch();
    rom_mem[0][0] = 16'hF800;
    set_ch(0, 1, 100, 50, 0, 0, 1);
    frame();
    send_pix(100, 50, 16'h001F, 1);
    n_vec++; if (out_rgb !== exp_rgb || out_ch !== 3'd0) begin
      n_err++; $display("FAIL half_alpha got=%h/%0d exp=%h/0", out_rgb, out_ch, exp_rgb); end
    fill_rom(0, 16'h07E0);
  endtask

  task automatic test_midreset();
    clear_ch();
    set_ch(0, 1, 100, 50, 0, 0, 0);
    frame();
    @(negedge CLK); pix_valid = 1; pix_x = 10'd100; pix_y = 10'd50;
    @(negedge CLK); pix_valid = 1; RSTn = 0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_ch !== 3'd7 || rom_addr !== '0) begin
      n_err++; $display("FAIL midreset got=%b/%0d/%h exp=0/7/0", out_valid, out_ch, rom_addr); end
    @(negedge CLK); RSTn = 1; pix_valid = 0;
    for (int i = 0; i < N_CH; i++) m_en[i] = 0;
    send_pix(100, 50, 16'h3333, 1);
    n_vec++; if (out_ch !== 3'd7 || out_rgb !== 16'h3333) begin
      n_err++; $display("FAIL midreset_flush got=%h/%0d exp=3333/7", out_rgb, out_ch); end
    frame();
    send_pix(100, 50, 16'h3333, 1);
    n_vec++; if (out_ch !== 3'd0) begin n_err++; $display("FAIL midreset_reload got=%0d exp=0", out_ch); end
  endtask

  task automatic test_back_to_back();
    localparam int NPIX = 400;
    logic [15:0] e_rgb [NPIX];
    logic [2:0]  e_ch [NPIX];
    bit          e_v [NPIX];
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < N_CH; i++) begin
        for (int a = 0; a < (1 << AW); a++)
          rom_mem[i][a] = ($urandom_range(3) == 0) ? KEY : 16'($urandom);
        set_ch(i, $urandom_range(7) != 0, $urandom_range(400), $urandom_range(300),
               1'($urandom), $urandom_range((1 << AW) - 1), 1'($urandom));
      end
      frame();
      for (int k = 0; k < NPIX + 2; k++) begin
        @(negedge CLK);
        if (k < NPIX) begin
          int px = $urandom_range(500);
          int py = $urandom_range(400);
          logic [15:0] bg = 16'($urandom);
          e_v[k] = ($urandom_range(9) != 0);
          pix_valid = e_v[k]; pix_x = 10'(px); pix_y = 10'(py); bg_rgb = bg;
          model(px, py, bg, e_rgb[k], e_ch[k]);
        end else begin
          pix_valid = 0;
        end
        @(posedge CLK); #1;
        if (k >= 2) begin
          n_vec++;
          if (out_valid !== e_v[k-2]) begin
            n_err++; $display("FAIL stream_valid idx=%0d got=%b exp=%b", k-2, out_valid, e_v[k-2]); end
          if (e_v[k-2]) begin
            n_vec++;
            if (out_rgb !== e_rgb[k-2] || out_ch !== e_ch[k-2]) begin
              n_err++; $display("FAIL stream_pix idx=%0d got=%h/%0d exp=%h/%0d",
                                k-2, out_rgb, out_ch, e_rgb[k-2], e_ch[k-2]); end
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      fill_rom(i, 16'h0);
      m_en[i] = 0; m_tw[i] = 0; m_half[i] = 0; m_x[i] = 0; m_y[i] = 0; m_base[i] = 0;
    end
    test_reset();
    test_basic();
    test_mirror();
    test_priority();
    test_collision();
    test_shadow();
    test_half();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
